fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the 16-deep x 8-bit FIFO between N_REQ producers.
- Arbitration is round-robin, with bounded bursts of up to BURST_MAX beats per grant.
- Sits directly in front of the FIFO: drives its wr/din and observes its full flag.
- The read side of the FIFO is untouched.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_arb_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Shared types and default constants for the FIFO write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DW_DEF        = 8;
    localparam int BURST_MAX_DEF = 4;
    localparam int STATS_W       = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_arb_rr_pick.sv
// ============================================================================
// Module  : fifo_arb_rr_pick
// Brief   : Combinational round-robin picker: first set request at or after
//           rr_ptr, wrapping modulo N_REQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int c_IW = $clog2(N_REQ);

    int w_pos;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        any   = |req;
        idx   = '0;
        w_pos = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_pos = (int'(rr_ptr) + i) % N_REQ;
            if (req[w_pos]) begin
                idx = c_IW'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin, burst-limited arbiter sharing one FIFO write port
//           between N_REQ producers. Optional per-producer ack counters are
//           enabled by defining FIFO_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      din_flat,
    output logic [N_REQ-1:0]         ack,
    output logic                     fifo_wr,
    output logic [DW-1:0]            fifo_din,
    input  logic                     fifo_full,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [N_REQ*STATS_W-1:0] stats_flat
`endif
);

    localparam int c_IW  = $clog2(N_REQ);
    localparam int c_BCW = $clog2(BURST_MAX + 1);
    localparam logic [c_BCW-1:0] c_BEAT_LAST = c_BCW'(BURST_MAX - 1);
    localparam logic [c_IW-1:0]  c_ID_LAST   = c_IW'(N_REQ - 1);

    arb_state_t         r_state;
    logic [c_IW-1:0]    r_rr_ptr;
    logic [c_IW-1:0]    r_grant_id;
    logic [c_BCW-1:0]   r_beat_cnt;

    logic               w_pick_any;
    logic [c_IW-1:0]    w_pick_idx;
    logic               w_req_g;
    logic               w_wr;
    logic [DW-1:0]      w_din;
    logic [c_IW-1:0]    w_next_ptr;

    fifo_arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .any    (w_pick_any),
        .idx    (w_pick_idx)
    );

    // Write is suppressed during reset so a burst cut by rst leaves no beat.
    always_comb begin
        w_req_g    = req[r_grant_id];
        w_wr       = (r_state == ARB_GRANT) && w_req_g && !fifo_full && !rst;
        w_next_ptr = (r_grant_id == c_ID_LAST) ? '0 : r_grant_id + 1'b1;
        w_din      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if ((r_state == ARB_GRANT) && (int'(r_grant_id) == k)) begin
                w_din = din_flat[k*DW +: DW];
            end
        end
    end

    assign fifo_wr  = w_wr;
    assign fifo_din = w_din;
    assign ack      = w_wr ? (N_REQ'(1) << r_grant_id) : '0;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ARB_GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_grant_id <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!w_req_g) begin
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_wr) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == c_BEAT_LAST) begin
                            r_state  <= ARB_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar k = 0; k < N_REQ; k++) begin : g_stats
        logic [STATS_W-1:0] r_cnt;

        // Clear takes priority over a coincident ack; count saturates.
        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                r_cnt <= '0;
            end else if (ack[k] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign stats_flat[k*STATS_W +: STATS_W] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Self-checking bench: directed vector table, randomized run against
//           a reference model, and FIFO_ARB_STATS_EN counter checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din_flat;
    logic [N-1:0]    ack;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full;
    logic [IW-1:0]   grant_id;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic            stats_clr;
    logic [N*16-1:0] stats_flat;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] seq [N];

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .BURST_MAX (BM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_flat  (din_flat),
        .ack       (ack),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .stats_flat(stats_flat)
`endif
    );

    always #5 clk = ~clk;

    // Producer k presents (k+1)*16 + sequence number, advancing on ack.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            din_flat[k*DW +: DW] = 8'((k + 1) * 16) + seq[k];
        end
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic         busy;
        logic [IW-1:0] gid;
        logic         wr;
        logic [7:0]   din;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [N-1:0] q, logic f, logic b,
                                logic [IW-1:0] g, logic w, logic [7:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.busy = b; v.gid = g; v.wr = w; v.din = d;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle_end();
        logic [N-1:0] a;
        a = ack;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (a[k] && !rst) seq[k] = seq[k] + 8'd1;
        end
        @(negedge clk);
    endtask

    // Reference model state
    bit m_busy;
    int m_g, m_beats, m_ptr, fcount;

    function automatic int rr_first(logic [N-1:0] q, int ptr);
        for (int o = 0; o < N; o++) begin
            if (q[(ptr + o) % N]) return (ptr + o) % N;
        end
        return -1;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [N-1:0] e_ack;
        bit  e_wr;
        logic [7:0] e_din;
        int  p;

        for (int k = 0; k < N; k++) seq[k] = 8'h00;
        rst = 1'b1; req = '0; fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);

        // ---------------- directed vector table ----------------
        add(1, 4'b0000, 0, 0, 0, 0, 8'h00);
        add(0, 4'b0001, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b0001, 0, 1, 0, 1, 8'(8'h10 + b));
        add(0, 4'b0001, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b0001, 0, 1, 0, 1, 8'(8'h14 + b));
        add(0, 4'b0000, 0, 0, 0, 0, 8'h00);
        add(1, 4'b1111, 0, 0, 0, 0, 8'h00);
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 1, 0, 1, 8'(8'h18 + b));
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 1, 1, 1, 8'(8'h20 + b));
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 1, 2, 1, 8'(8'h30 + b));
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 1, 3, 1, 8'(8'h40 + b));
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        // FIFO full after 16 writes: grant held, no write, beat count frozen
        add(0, 4'b1111, 1, 1, 0, 0, 8'h1C);
        add(0, 4'b1111, 1, 1, 0, 0, 8'h1C);
        add(0, 4'b1111, 0, 1, 0, 1, 8'h1C);
        add(0, 4'b1111, 1, 1, 0, 0, 8'h1D);
        add(0, 4'b1111, 0, 1, 0, 1, 8'h1D);
        add(0, 4'b1111, 0, 1, 0, 1, 8'h1E);
        add(0, 4'b1111, 0, 1, 0, 1, 8'h1F);
        add(0, 4'b0000, 0, 0, 0, 0, 8'h00);
        // producer 2 drops after 2 beats; next goes to 3
        add(0, 4'b0100, 0, 0, 0, 0, 8'h00);
        add(0, 4'b0100, 0, 1, 2, 1, 8'h34);
        add(0, 4'b0100, 0, 1, 2, 1, 8'h35);
        add(0, 4'b0000, 0, 1, 2, 0, 8'h36);
        add(0, 4'b1001, 0, 0, 0, 0, 8'h00);
        add(0, 4'b1001, 0, 1, 3, 1, 8'h44);
        add(0, 4'b0000, 0, 1, 3, 0, 8'h45);
        // producer 2 drops again; 3 idle so wraps to 0
        add(0, 4'b0100, 0, 0, 0, 0, 8'h00);
        add(0, 4'b0100, 0, 1, 2, 1, 8'h36);
        add(0, 4'b0000, 0, 1, 2, 0, 8'h37);
        add(0, 4'b0011, 0, 0, 0, 0, 8'h00);
        add(0, 4'b0011, 0, 1, 0, 1, 8'h20);
        add(0, 4'b0000, 0, 1, 0, 0, 8'h21);
        // reset on beat 3 of producer 1's burst; pointer returns to 0
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        add(0, 4'b1111, 0, 1, 1, 1, 8'h24);
        add(0, 4'b1111, 0, 1, 1, 1, 8'h25);
        add(1, 4'b1111, 0, 1, 1, 0, 8'h26);
        add(0, 4'b1111, 0, 0, 0, 0, 8'h00);
        add(0, 4'b1111, 0, 1, 0, 1, 8'h21);
        add(0, 4'b0000, 0, 1, 0, 0, 8'h22);
        add(0, 4'b0000, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst = v.rst; req = v.req; fifo_full = v.full;
            #4;
            e_ack = v.wr ? (N'(1) << v.gid) : '0;
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(v.busy));
            chk($sformatf("row%0d fifo_wr", i), 32'(fifo_wr), 32'(v.wr));
            chk($sformatf("row%0d ack", i), 32'(ack), 32'(e_ack));
            chk($sformatf("row%0d fifo_din", i), 32'(fifo_din), 32'(v.din));
            if (v.busy || v.rst) chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(v.gid));
            cycle_end();
        end

        // ---------------- randomized run vs reference model ----------------
        fcount = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
            end
            fifo_full = (fcount == 16);
            #4;
            e_wr  = m_busy && req[m_g] && !fifo_full && !rst;
            e_din = m_busy ? 8'((m_g + 1) * 16) + seq[m_g] : 8'h00;
            e_ack = e_wr ? (N'(1) << m_g) : '0;
            if (c > 0) begin
                chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy));
                chk($sformatf("rnd%0d fifo_wr", c), 32'(fifo_wr), 32'(e_wr));
                chk($sformatf("rnd%0d ack", c), 32'(ack), 32'(e_ack));
                chk($sformatf("rnd%0d fifo_din", c), 32'(fifo_din), 32'(e_din));
                if (m_busy) chk($sformatf("rnd%0d grant_id", c), 32'(grant_id), 32'(m_g));
            end
            if (rst) begin
                m_busy = 0; m_g = 0; m_beats = 0; m_ptr = 0;
            end else if (!m_busy) begin
                p = rr_first(req, m_ptr);
                if (p >= 0) begin
                    m_busy = 1; m_g = p; m_beats = 0;
                end
            end else if (!req[m_g]) begin
                m_busy = 0; m_ptr = (m_g + 1) % N;
            end else if (e_wr) begin
                m_beats++;
                if (m_beats == BM) begin
                    m_busy = 0; m_ptr = (m_g + 1) % N;
                end
            end
            if (fcount > 0 && $urandom_range(0, 2) == 0) fcount--;
            if (e_wr) fcount++;
            cycle_end();
        end

`ifdef FIFO_ARB_STATS_EN
        begin
            int acks, cyc;
            bit seen;
            rst = 1'b0; req = '0; fifo_full = 1'b0; stats_clr = 1'b1;
            cycle_end();
            stats_clr = 1'b0;
            #4;
            for (int k = 0; k < N; k++)
                chk($sformatf("stats%0d after clr", k), 32'(stats_flat[k*16 +: 16]), 32'h0);
            acks = 0; cyc = 0;
            req = 4'b0010;
            while (acks < 66000 && cyc < 90000) begin
                #4;
                if (ack[1]) acks++;
                cyc++;
                cycle_end();
            end
            req = '0;
            chk("stats ack budget", 32'(acks), 32'd66000);
            cycle_end();
            cycle_end();
            #4;
            for (int k = 0; k < N; k++)
                chk($sformatf("stats%0d saturate", k), 32'(stats_flat[k*16 +: 16]),
                    (k == 1) ? 32'hFFFF : 32'h0);
            cycle_end();
            req = 4'b0010;
            seen = 0;
            for (int t = 0; t < 20 && !seen; t++) begin
                #4;
                if (ack[1]) begin
                    seen = 1;
                    stats_clr = 1'b1;
                end
                cycle_end();
            end
            stats_clr = 1'b0;
            req = '0;
            chk("stats clr-vs-ack seen", 32'(seen), 32'd1);
            #4;
            chk("stats1 clr wins", 32'(stats_flat[16 +: 16]), 32'h0);
            cycle_end();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
